// File: rtl/oa21_vec_pipe.sv
// oa21_vec_pipe: WIDTH-lane registered OA21, Q = (IN1 | IN2) & IN3,
// with a STAGES-deep valid pipeline and a saturating Q toggle counter.
module oa21_vec_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic             EN,
  input  logic [WIDTH-1:0] IN1,
  input  logic [WIDTH-1:0] IN2,
  input  logic [WIDTH-1:0] IN3,
  input  logic             CLR,
  output logic [WIDTH-1:0] Q,
  output logic             QV,
  output logic [CNT_W-1:0] TGL_CNT,
  output logic             TGL_SAT
);

  localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

  logic [WIDTH-1:0] lane;
  logic [WIDTH-1:0] last_d;
  logic             last_v;
  logic [WIDTH-1:0] flips;
  logic [CNT_W:0]   flip_cnt;
  logic [CNT_W:0]   cnt_sum;
  logic             hit_max;

  assign lane = (IN1 | IN2) & IN3;

  // Q is itself the final register, so only STAGES-1 stages sit in front of it.
  generate
    if (STAGES == 1) begin : g_direct
      assign last_d = lane;
      assign last_v = EN;
    end else begin : g_pipe
      logic [STAGES-2:0][WIDTH-1:0] pd;
      logic [STAGES-2:0]            pv;

      // Stage 0 captures on EN; later stages shift every cycle.
      always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
          pd <= '0;
          pv <= '0;
        end else begin
          pv[0] <= EN;
          if (EN) begin
            pd[0] <= lane;
          end
          for (int i = 1; i < STAGES - 1; i++) begin
            pd[i] <= pd[i-1];
            pv[i] <= pv[i-1];
          end
        end
      end

      assign last_d = pd[STAGES-2];
      assign last_v = pv[STAGES-2];
    end
  endgenerate

  // Count bits that flip between the held Q and the arriving result.
  always_comb begin
    flips    = Q ^ last_d;
    flip_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      flip_cnt = flip_cnt + {{CNT_W{1'b0}}, flips[i]};
    end
    cnt_sum = {1'b0, TGL_CNT} + flip_cnt;
  end

  assign hit_max = (cnt_sum >= CNT_MAX);

  // Output register: load on last-stage valid, otherwise hold.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      Q  <= '0;
      QV <= 1'b0;
    end else begin
      QV <= last_v;
      if (last_v) begin
        Q <= last_d;
      end
    end
  end

  // Saturating toggle counter; a same-cycle clear discards the update.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      TGL_CNT <= '0;
      TGL_SAT <= 1'b0;
    end else if (CLR) begin
      TGL_CNT <= '0;
      TGL_SAT <= 1'b0;
    end else if (last_v) begin
      TGL_CNT <= hit_max ? CNT_MAX[CNT_W-1:0] : cnt_sum[CNT_W-1:0];
      if (hit_max) begin
        TGL_SAT <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_oa21_vec_pipe.sv
// tb_oa21_vec_pipe: scenario tasks plus random traffic, checked against
// a queue-based model of the sample-to-Q latency and toggle accounting.
module tb_oa21_vec_pipe;

  localparam int STAGES = 2;
  localparam int MAX_A  = 65535;
  localparam int MAX_S  = 15;

  logic       CLK = 1'b0;
  logic       RSTB;
  logic       EN;
  logic       CLR;
  logic [7:0] IN1, IN2, IN3;

  logic [7:0]  q_a, q_s;
  logic        qv_a, qv_s;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_s;
  logic        sat_a, sat_s;

  oa21_vec_pipe #(.WIDTH(8), .STAGES(STAGES), .CNT_W(16)) u_a (
    .CLK(CLK), .RSTB(RSTB), .EN(EN), .IN1(IN1), .IN2(IN2), .IN3(IN3),
    .CLR(CLR), .Q(q_a), .QV(qv_a), .TGL_CNT(cnt_a), .TGL_SAT(sat_a)
  );

  oa21_vec_pipe #(.WIDTH(8), .STAGES(STAGES), .CNT_W(4)) u_s (
    .CLK(CLK), .RSTB(RSTB), .EN(EN), .IN1(IN1), .IN2(IN2), .IN3(IN3),
    .CLR(CLR), .Q(q_s), .QV(qv_s), .TGL_CNT(cnt_s), .TGL_SAT(sat_s)
  );

  always #5 CLK = ~CLK;

  logic [8:0] pipe[$];
  logic [7:0] m_q;
  logic       m_qv;
  int         m_ca, m_cs;
  logic       m_sa, m_ss;

  int n_cmp = 0;
  int n_bad = 0;

  wire [39:0] obs = {q_a, qv_a, cnt_a, sat_a, q_s, qv_s, cnt_s, sat_s};

  function automatic logic [39:0] model_vec();
    return {m_q, m_qv, 16'(m_ca), m_sa, m_q, m_qv, 4'(m_cs), m_ss};
  endfunction

  task automatic reset_model();
    pipe.delete();
    m_q  = '0;
    m_qv = 1'b0;
    m_ca = 0;
    m_cs = 0;
    m_sa = 1'b0;
    m_ss = 1'b0;
  endtask

  task automatic step(input logic en, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] c,
                      input logic clr);
    logic [8:0] s;
    int d, sum;
    EN  = en;
    IN1 = a;
    IN2 = b;
    IN3 = c;
    CLR = clr;
    @(posedge CLK);
    if (!RSTB) begin
      reset_model();
    end else begin
      pipe.push_back({en, (a | b) & c});
      m_qv = 1'b0;
      if (pipe.size() >= STAGES) begin
        s = pipe.pop_front();
        if (s[8]) begin
          d    = $countones(m_q ^ s[7:0]);
          m_q  = s[7:0];
          m_qv = 1'b1;
          sum  = m_ca + d;
          if (sum >= MAX_A) m_sa = 1'b1;
          m_ca = (sum > MAX_A) ? MAX_A : sum;
          sum  = m_cs + d;
          if (sum >= MAX_S) m_ss = 1'b1;
          m_cs = (sum > MAX_S) ? MAX_S : sum;
        end
      end
      if (clr) begin
        m_ca = 0;
        m_cs = 0;
        m_sa = 1'b0;
        m_ss = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
  endtask

  task automatic test_reset();
    RSTB = 1'b0;
    EN   = 1'b1;
    CLR  = 1'b0;
    IN1  = 8'hFF;
    IN2  = 8'hFF;
    IN3  = 8'hFF;
    reset_model();
    #2;
    n_cmp++;
    if (obs !== 40'h0) begin
      n_bad++;
      $display("FAIL reset_async: got %h want %h", obs, 40'h0);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      n_cmp++;
      if (obs !== 40'h0) begin
        n_bad++;
        $display("FAIL reset_hold[%0d]: got %h want %h", i, obs, 40'h0);
      end
    end
    RSTB = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      n_cmp++;
      if ({qv_a, qv_s} !== 2'b00 || obs !== model_vec()) begin
        n_bad++;
        $display("FAIL reset_release[%0d]: got %h want %h", i, obs, model_vec());
      end
    end
  endtask

  task automatic test_single();
    step(1'b1, 8'h0F, 8'hF0, 8'h3C, 1'b0);
    n_cmp++;
    if ({q_a, qv_a} !== {8'h00, 1'b0}) begin
      n_bad++;
      $display("FAIL single_early: got %h/%b want 00/0", q_a, qv_a);
    end
    idle();
    n_cmp++;
    if ({q_a, qv_a, cnt_a, sat_a} !== {8'h3C, 1'b1, 16'd4, 1'b0}
        || obs !== model_vec()) begin
      n_bad++;
      $display("FAIL single_out: got %h want %h", obs, model_vec());
    end
    idle();
    n_cmp++;
    if ({q_a, qv_a, cnt_a} !== {8'h3C, 1'b0, 16'd4} || obs !== model_vec()) begin
      n_bad++;
      $display("FAIL single_hold: got %h want %h", obs, model_vec());
    end
  endtask

  task automatic test_back_to_back();
    RSTB = 1'b0;
    idle();
    RSTB = 1'b1;
    step(1'b1, 8'h0F, 8'hF0, 8'h3C, 1'b0);
    step(1'b1, 8'hFF, 8'h00, 8'hC3, 1'b0);
    n_cmp++;
    if ({q_a, qv_a, cnt_a} !== {8'h3C, 1'b1, 16'd4} || obs !== model_vec()) begin
      n_bad++;
      $display("FAIL b2b_first: got %h want %h", obs, model_vec());
    end
    idle();
    n_cmp++;
    if ({q_a, qv_a, cnt_a} !== {8'hC3, 1'b1, 16'd12} || obs !== model_vec()) begin
      n_bad++;
      $display("FAIL b2b_second: got %h want %h", obs, model_vec());
    end
    idle();
    n_cmp++;
    if (qv_a !== 1'b0 || obs !== model_vec()) begin
      n_bad++;
      $display("FAIL b2b_end: got %h want %h", obs, model_vec());
    end
  endtask

  task automatic test_bubble();
    logic [2:0] qv_seen;
    step(1'b1, 8'h55, 8'h00, 8'hFF, 1'b0);
    step(1'b0, 8'h55, 8'h00, 8'hFF, 1'b0);
    qv_seen[2] = qv_a;
    n_cmp++;
    if ({q_a, cnt_a} !== {8'h55, 16'd16} || obs !== model_vec()) begin
      n_bad++;
      $display("FAIL bubble_first: got %h want %h", obs, model_vec());
    end
    step(1'b1, 8'h55, 8'h00, 8'hFF, 1'b0);
    qv_seen[1] = qv_a;
    idle();
    qv_seen[0] = qv_a;
    n_cmp++;
    if ({q_a, cnt_a} !== {8'h55, 16'd16} || obs !== model_vec()) begin
      n_bad++;
      $display("FAIL bubble_repeat: got %h want %h", obs, model_vec());
    end
    n_cmp++;
    if (qv_seen !== 3'b101) begin
      n_bad++;
      $display("FAIL bubble_qv: got %b want 101", qv_seen);
    end
    idle();
  endtask

  task automatic test_saturation();
    step(1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
    step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    step(1'b1, 8'hFF, 8'h00, 8'hFF, 1'b0);
    step(1'b1, 8'h00, 8'h00, 8'hFF, 1'b0);
    n_cmp++;
    if ({q_s, cnt_s, sat_s, cnt_a} !== {8'hFF, 4'd8, 1'b0, 16'd8}
        || obs !== model_vec()) begin
      n_bad++;
      $display("FAIL sat_first: got %h want %h", obs, model_vec());
    end
    step(1'b1, 8'hFF, 8'h00, 8'hFF, 1'b0);
    n_cmp++;
    if ({q_s, cnt_s, sat_s, cnt_a} !== {8'h00, 4'd15, 1'b1, 16'd16}
        || obs !== model_vec()) begin
      n_bad++;
      $display("FAIL sat_clamp: got %h want %h", obs, model_vec());
    end
    step(1'b1, 8'h00, 8'h00, 8'hFF, 1'b0);
    idle();
    n_cmp++;
    if ({cnt_s, sat_s, cnt_a, sat_a} !== {4'd15, 1'b1, 16'd32, 1'b0}
        || obs !== model_vec()) begin
      n_bad++;
      $display("FAIL sat_sticky: got %h want %h", obs, model_vec());
    end
    idle();
  endtask

  task automatic test_clr_and_reset();
    step(1'b1, 8'h12, 8'h21, 8'hFF, 1'b0);
    step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    n_cmp++;
    if ({q_a, qv_a, cnt_a, sat_a, cnt_s, sat_s}
        !== {8'h33, 1'b1, 16'd0, 1'b0, 4'd0, 1'b0}
        || obs !== model_vec()) begin
      n_bad++;
      $display("FAIL clr_update: got %h want %h", obs, model_vec());
    end
    step(1'b1, 8'hA5, 8'h00, 8'hFF, 1'b0);
    step(1'b1, 8'h5A, 8'h00, 8'hFF, 1'b0);
    EN  = 1'b1;
    IN1 = 8'hF0;
    #2;
    RSTB = 1'b0;
    reset_model();
    #1;
    n_cmp++;
    if (obs !== 40'h0) begin
      n_bad++;
      $display("FAIL mid_reset: got %h want %h", obs, 40'h0);
    end
    idle();
    idle();
    RSTB = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle();
      n_cmp++;
      if ({q_a, qv_a, qv_s} !== 10'h0 || obs !== model_vec()) begin
        n_bad++;
        $display("FAIL post_reset[%0d]: got %h want %h", i, obs, model_vec());
      end
    end
  endtask

  task automatic test_random();
    logic en, clr;
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(3) != 0);
      clr = ($urandom_range(19) == 0);
      step(en, 8'($urandom), 8'($urandom), 8'($urandom), clr);
      n_cmp++;
      if (obs !== model_vec()) begin
        n_bad++;
        $display("FAIL random[%0d]: got %h want %h", i, obs, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_bubble();
    test_saturation();
    test_clr_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
